// File: rtl/debug_uart_dumper.sv
// Debug-channel dump sequencer: steps the one-hot mux select through all channels,
// latches each 32-bit value and sends "<ch>:<8 hex digits>\r\n" over an 8N1 UART.
module debug_uart_dumper #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned NUM_CH       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] result,
  output logic [7:0]  select,
  output logic        uart_txd,
  output logic        busy,
  output logic        done
);

  localparam int unsigned BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    CH_LAST   = 3'(NUM_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEL,
    S_LATCH,
    S_SEND,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [7:0]    r_select;
  logic          r_txd;
  logic          r_busy;
  logic          r_done;
  logic [2:0]    r_ch;
  logic [31:0]   r_data;
  logic [BW-1:0] r_baud;
  logic [3:0]    r_bit;
  logic [3:0]    r_byte;

  logic [2:0]    w_nidx;
  logic [3:0]    w_nib;
  logic [7:0]    w_byte;

  // ch0 uses the all-zero code; channels 1..7 walk a single one through bits 0..6
  function automatic logic [7:0] sel_code(input logic [2:0] ch);
    return (ch == 3'd0) ? 8'h00 : (8'h01 << (ch - 3'd1));
  endfunction

  // Bytes 2..9 carry nibbles 7..0 of the latched value
  always_comb begin
    w_nidx = 3'(4'd9 - r_byte);
    w_nib  = r_data[{w_nidx, 2'b00} +: 4];
    case (r_byte)
      4'd0:    w_byte = 8'h30 + {5'b0, r_ch};
      4'd1:    w_byte = 8'h3A;
      4'd10:   w_byte = 8'h0D;
      4'd11:   w_byte = 8'h0A;
      default: w_byte = (w_nib < 4'd10) ? (8'h30 + {4'b0, w_nib})
                                        : (8'h37 + {4'b0, w_nib});
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_select <= 8'h00;
      r_txd    <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ch     <= '0;
      r_data   <= '0;
      r_baud   <= '0;
      r_bit    <= '0;
      r_byte   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_SEL;
            r_ch     <= 3'd0;
            r_select <= sel_code(3'd0);
            r_busy   <= 1'b1;
          end
        end
        S_SEL: r_state <= S_LATCH;
        S_LATCH: begin
          r_data  <= result;
          r_txd   <= 1'b0;
          r_baud  <= '0;
          r_bit   <= '0;
          r_byte  <= '0;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (r_baud == BAUD_LAST) begin
            r_baud <= '0;
            if (r_bit == 4'd9) begin
              if (r_byte == 4'd11) begin
                r_txd <= 1'b1;
                if (r_ch == CH_LAST) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                end else begin
                  r_ch     <= 3'(r_ch + 3'd1);
                  r_select <= sel_code(3'(r_ch + 3'd1));
                  r_state  <= S_SEL;
                end
              end else begin
                r_byte <= r_byte + 4'd1;
                r_bit  <= 4'd0;
                r_txd  <= 1'b0;
              end
            end else begin
              // r_bit is the bit just finished; the next one is data bit r_bit or the stop bit
              r_bit <= r_bit + 4'd1;
              r_txd <= (r_bit == 4'd8) ? 1'b1 : w_byte[r_bit[2:0]];
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign select   = r_select;
  assign uart_txd = r_txd;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
